// File: rtl/result_tx_pkg.sv
// Shared types and constants for the result UART transmitter:
// serializer states, packet geometry and the packet checksum.
package result_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int         BYTES_PER_PKT  = 5;
  localparam int         BITS_PER_BYTE  = 10;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  function automatic logic [7:0] calc_chk(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Serializes one byte as start bit, 8 data bits LSB first and a stop bit.
// A load during the last stop-bit cycle chains the next byte with no gap.
module uart_byte_tx
  import result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_byte_in,
  output logic       o_busy,
  output logic       o_byte_done,
  output logic       o_tx
);

  localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);

  tx_state_e     r_state;
  tx_state_e     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_tx;
  logic          w_tx_nxt;
  logic          w_tick;

  assign w_tick      = (r_cnt == LAST_CNT);
  assign o_busy      = (r_state != IDLE);
  assign o_byte_done = (r_state == STOP) && w_tick;
  assign o_tx        = r_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_tick ? '0 : r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_tx_nxt  = 1'b1;
        if (i_load) begin
          w_state_nxt = START;
          w_shift_nxt = i_byte_in;
          w_tx_nxt    = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        // Chaining straight into the next start bit keeps bytes gapless.
        if (w_tick && i_load) begin
          w_state_nxt = START;
          w_shift_nxt = i_byte_in;
          w_tx_nxt    = 1'b0;
        end else if (w_tick) begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/result_uart_tx.sv
// Packet sequencer: captures v1..v3 on start and sends
// HEADER, v1, v2, v3, v1^v2^v3 back to back through uart_byte_tx.
module result_uart_tx
  import result_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] v1,
  input  logic [7:0] v2,
  input  logic [7:0] v3,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_PKT - 1);

  logic [7:0] r_v1;
  logic [7:0] r_v2;
  logic [7:0] r_v3;
  logic [7:0] r_chk;
  logic [2:0] r_byte_idx;
  logic       r_sending;
  logic       r_load_first;
  logic       r_busy;
  logic       r_done;

  logic       w_accept;
  logic       w_load;
  logic       w_last_done;
  logic [2:0] w_sel;
  logic [7:0] w_byte;
  logic       w_byte_busy;
  logic       w_byte_done;
  logic       w_tx;

  assign w_accept    = start && !r_sending && !w_byte_busy;
  assign w_last_done = w_byte_done && (r_byte_idx == LAST_IDX);
  assign w_load      = r_load_first || (w_byte_done && (r_byte_idx != LAST_IDX));
  // The chained load during a stop bit already selects the following byte.
  assign w_sel       = r_load_first ? r_byte_idx : r_byte_idx + 3'd1;

  assign busy = r_busy;
  assign done = r_done;
  assign tx   = w_tx;

  always_comb begin
    w_byte = HEADER;
    case (w_sel)
      3'd0:    w_byte = HEADER;
      3'd1:    w_byte = r_v1;
      3'd2:    w_byte = r_v2;
      3'd3:    w_byte = r_v3;
      3'd4:    w_byte = r_chk;
      default: w_byte = HEADER;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1         <= 8'h00;
      r_v2         <= 8'h00;
      r_v3         <= 8'h00;
      r_chk        <= 8'h00;
      r_byte_idx   <= 3'd0;
      r_sending    <= 1'b0;
      r_load_first <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_load_first <= w_accept;
      r_done       <= w_last_done;
      if (w_accept) begin
        r_v1       <= v1;
        r_v2       <= v2;
        r_v3       <= v3;
        r_chk      <= calc_chk(v1, v2, v3);
        r_byte_idx <= 3'd0;
        r_sending  <= 1'b1;
      end else if (w_last_done) begin
        r_sending  <= 1'b0;
      end else if (w_byte_done) begin
        r_byte_idx <= r_byte_idx + 3'd1;
      end else begin
        r_sending  <= r_sending;
      end
      if (r_load_first) begin
        r_busy <= 1'b1;
      end else if (w_last_done) begin
        r_busy <= 1'b0;
      end else begin
        r_busy <= r_busy;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_byte_in  (w_byte),
    .o_busy     (w_byte_busy),
    .o_byte_done(w_byte_done),
    .o_tx       (w_tx)
  );

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: per-cycle traces of tx/busy/done
// are compared against an expected waveform built from the packet rules.
module tb_result_uart_tx;

  localparam int CPB     = 4;
  localparam int PKT_CYC = 5 * 10 * CPB;
  localparam int NMAX    = 512;

  typedef struct {
    logic [7:0] v1;
    logic [7:0] v2;
    logic [7:0] v3;
    logic [7:0] chk;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] v1, v2, v3;
  logic       busy, done, tx;

  int n_pass  = 0;
  int n_total = 0;

  logic tx_q   [NMAX];
  logic busy_q [NMAX];
  logic done_q [NMAX];
  logic exp_tx  [NMAX];
  logic exp_busy[NMAX];
  logic exp_done[NMAX];

  vec_t tbl[4];

  result_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk  (clk),
    .rst  (rst),
    .v1   (v1),
    .v2   (v2),
    .v3   (v3),
    .start(start),
    .busy (busy),
    .done (done),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Present inputs and pulse start; returns just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    v1 = a; v2 = b; v3 = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Sample i is taken just after edge i+1 counted from the accepting edge.
  task automatic record(input int n, input int inj,
                        input logic [7:0] na, input logic [7:0] nb, input logic [7:0] nc);
    for (int i = 0; i < n; i++) begin
      step();
      tx_q[i] = tx; busy_q[i] = busy; done_q[i] = done;
      start = (i == inj);
      if (i == inj) begin v1 = na; v2 = nb; v3 = nc; end
    end
    start = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NMAX; i++) begin
      exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
    end
  endtask

  // Packet accepted at edge a: bit k of the 50-bit frame stream spans samples a+4k..a+4k+3.
  task automatic model_add(input int a, input logic [39:0] pkt);
    logic [7:0] byt;
    logic       bv;
    for (int j = 0; j < 5; j++) begin
      byt = pkt[39 - 8*j -: 8];
      for (int f = 0; f < 10; f++) begin
        bv = (f == 0) ? 1'b0 : (f == 9) ? 1'b1 : byt[f-1];
        for (int c = 0; c < CPB; c++) exp_tx[a + (j*10 + f)*CPB + c] = bv;
      end
    end
    for (int k = 0; k < PKT_CYC; k++) exp_busy[a + k] = 1'b1;
    exp_done[a + PKT_CYC] = 1'b1;
  endtask

  task automatic compare(input string tag, input int n);
    int etx = 0, eb = 0, ed = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_q[i]   !== exp_tx[i])   etx++;
      if (busy_q[i] !== exp_busy[i]) eb++;
      if (done_q[i] !== exp_done[i]) ed++;
    end
    check({tag, " tx trace wrong samples"},   etx, 0);
    check({tag, " busy trace wrong samples"}, eb,  0);
    check({tag, " done trace wrong samples"}, ed,  0);
  endtask

  function automatic int count_hi(input int n, input bit use_done);
    int c = 0;
    for (int i = 0; i < n; i++) c += use_done ? int'(done_q[i] === 1'b1) : int'(busy_q[i] === 1'b1);
    return c;
  endfunction

  // Mid-bit UART decode of the first frame found in the recorded tx trace.
  function automatic logic [39:0] decode(input int n);
    int         base = -1;
    int         idx;
    logic [39:0] r = 40'h0;
    for (int i = 0; i < n && base < 0; i++) if (tx_q[i] === 1'b0) base = i;
    if (base < 0) return 40'h0;
    for (int j = 0; j < 5; j++) begin
      for (int b = 0; b < 8; b++) begin
        idx = base + (j*10 + 1 + b)*CPB + CPB/2;
        if (idx < n) r[39 - 8*j - 7 + b] = tx_q[idx];
      end
    end
    return r;
  endfunction

  task automatic run_plain(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] ck);
    logic [39:0] pkt;
    pkt = {8'hA5, a, b, c, ck};
    send(a, b, c);
    record(PKT_CYC + 4, -1, 8'h00, 8'h00, 8'h00);
    model_clear();
    model_add(0, pkt);
    compare(tag, PKT_CYC + 4);
    check({tag, " busy cycles"}, count_hi(PKT_CYC + 4, 1'b0), PKT_CYC);
    check({tag, " done pulses"}, count_hi(PKT_CYC + 4, 1'b1), 1);
    check({tag, " decoded bytes"}, decode(PKT_CYC + 4), pkt);
  endtask

  initial begin
    logic [7:0] ra, rb, rc;
    logic [39:0] p1, p2;
    tbl[0] = '{v1: 8'h0A, v2: 8'h14, v3: 8'h1E, chk: 8'h00};
    tbl[1] = '{v1: 8'hFF, v2: 8'h00, v3: 8'h81, chk: 8'h7E};
    tbl[2] = '{v1: 8'h00, v2: 8'h00, v3: 8'h00, chk: 8'h00};
    tbl[3] = '{v1: 8'h12, v2: 8'h34, v3: 8'h56, chk: 8'h70};

    rst = 1'b1; start = 1'b0; v1 = 8'h00; v2 = 8'h00; v3 = 8'h00;
    step(); step();
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    rst = 1'b0;
    step(); step(); step();
    check("idle tx", tx, 1'b1);

    for (int t = 0; t < 4; t++) begin
      run_plain($sformatf("table%0d", t), tbl[t].v1, tbl[t].v2, tbl[t].v3, tbl[t].chk);
      step();
    end

    for (int r = 0; r < 6; r++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255));
      run_plain($sformatf("random%0d", r), ra, rb, rc, ra ^ rb ^ rc);
      repeat ($urandom_range(0, 5)) step();
    end

    // Second start 20 cycles in, with v1 changed, must be ignored.
    p1 = {8'hA5, 8'h33, 8'h44, 8'h66, 8'h33 ^ 8'h44 ^ 8'h66};
    send(8'h33, 8'h44, 8'h66);
    record(PKT_CYC + 4, 19, 8'h55, 8'h44, 8'h66);
    model_clear();
    model_add(0, p1);
    compare("ignored start", PKT_CYC + 4);
    check("ignored start done pulses", count_hi(PKT_CYC + 4, 1'b1), 1);
    step();

    // Start on the done cycle chains a second packet.
    p1 = {8'hA5, 8'h01, 8'h02, 8'h04, 8'h07};
    p2 = {8'hA5, 8'hC3, 8'h3C, 8'h99, 8'hC3 ^ 8'h3C ^ 8'h99};
    send(8'h01, 8'h02, 8'h04);
    record(2*PKT_CYC + 6, PKT_CYC, 8'hC3, 8'h3C, 8'h99);
    model_clear();
    model_add(0, p1);
    model_add(PKT_CYC + 2, p2);
    compare("back to back", 2*PKT_CYC + 6);
    check("back to back busy cycles", count_hi(2*PKT_CYC + 6, 1'b0), 2*PKT_CYC);
    check("back to back done pulses", count_hi(2*PKT_CYC + 6, 1'b1), 2);
    step();

    // Reset 90 cycles in while tx is low: line must go high with no clock edge.
    send(8'h00, 8'h00, 8'h00);
    record(90, -1, 8'h00, 8'h00, 8'h00);
    check("pre-reset tx low", tx, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async reset tx", tx, 1'b1);
    check("async reset busy", busy, 1'b0);
    step(); step();
    rst = 1'b0;
    record(40, -1, 8'h00, 8'h00, 8'h00);
    model_clear();
    compare("after reset", 40);
    run_plain("post reset packet", tbl[0].v1, tbl[0].v2, tbl[0].v3, tbl[0].chk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
Downstream output stage of the DSP processor. It captures the three 8-bit result bytes (v1, v2, v3) on a start strobe and transmits them over a UART line as one framed packet. The packet is: header, v1, v2, v3, checksum. This gives the host a serial readout of processor results without relying on board LEDs.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
HEADER, 8'hA5, first byte of every packet.

Ports:
clk  in  1  system clock (same clk that drives the processor).
rst  in  1  asynchronous, active-high reset.
v1  in  8  result byte 1.
v2  in  8  result byte 2.
v3  in  8  result byte 3.
start  in  1  single-cycle request to send one packet.
busy  out  1  high from the cycle after start is accepted until the packet completes.
done  out  1  one-cycle pulse when the last stop bit ends.
tx  out  1  UART line; idle high.

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high.
- Reset values: tx=1, busy=0, done=0, state=IDLE, all counters 0, capture registers 0.
- Reset asserted mid-packet: tx returns to 1 immediately (asynchronous). The packet is abandoned and is not resumed after reset releases.
- Acceptance: start is sampled only in IDLE. On the accepting edge the block:
  - latches v1, v2, v3 into capture registers;
  - computes chk = v1 ^ v2 ^ v3;
  - loads byte index = 0.
- start seen while busy=1 is ignored; there is no queuing.
- Inputs that change after acceptance do not affect the packet in flight.
- Byte order: HEADER, v1, v2, v3, chk (byte index 0..4).
- Bit framing per byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- There are no gaps between bytes: the next start bit follows the previous stop bit directly.
- Latency:
  - tx falls, and busy rises, on the first clock edge after the accepting edge.
  - The packet occupies 5*10*CLKS_PER_BIT cycles of tx activity.
- Completion: at the end of the 5th stop bit the block returns to IDLE. busy falls and done pulses high for exactly one cycle, both on the same edge.
- A start on the cycle that done is high is accepted, because the state is already IDLE. This allows back-to-back packets with no idle gap.
- State machine:
  - IDLE -> START on start.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bit periods.
  - STOP -> START if byte index < 4 (byte index increments).
  - STOP -> IDLE if byte index == 4.
- Counters:
  - baud counter: width clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, wraps to 0 and emits a tick on wrap.
  - bit index: 3 bits.
  - byte index: 3 bits.
- tx is driven from a register, so it carries no combinational glitches.

Decomposition:
- Package result_tx_pkg:
  - state enum {IDLE, START, DATA, STOP};
  - BYTES_PER_PKT = 5;
  - BITS_PER_BYTE = 10;
  - HEADER default constant.
- Sub-module uart_byte_tx handles baud counting and the start/data/stop serialization of one byte. Its interface is load/byte_in/busy/byte_done/tx.
- result_uart_tx is the packet sequencer. It handles capture, checksum and byte-index control around uart_byte_tx.

Test Plan:
- CLKS_PER_BIT=4; v1=0x0A, v2=0x14, v3=0x1E; pulse start -> tx decodes to A5 0A 14 1E 00. busy is high for exactly 200 cycles, then done pulses once.
- v1=0xFF, v2=0x00, v3=0x81; start -> bytes A5 FF 00 81 7E. Each bit is 4 cycles wide; the stop bits are 1.
- Second start pulse 20 cycles into a packet, with v1 changed to 0x55 -> ignored. The packet still carries the original captured bytes, and only one done pulse occurs.
- rst asserted at cycle 90 of a packet -> tx=1, busy=0 immediately with no clock edge needed. After release, tx stays 1 until a new start is given.
- start held high on the done cycle -> a second packet begins on the next edge; tx falls with no idle bit; total 400 busy cycles with one done pulse per packet.
